hex2ascii_tx: RTL and testbench
===============================

HEX2ASCII_TX -- requirements
Module: hex2ascii_tx

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge system clock; all state changes on this edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on clk.
REQ-004 data_in  input  8  binary byte to be rendered as two ASCII hex characters.
REQ-005 data_valid  input  1  data_in is valid this cycle.
REQ-006 data_ready  output  1  block accepts a byte this cycle; registered.
REQ-007 ascii_out  output  8  ASCII character toward the UART transmitter; registered.
REQ-008 ascii_valid  output  1  ascii_out holds a character; registered.
REQ-009 ascii_ready  input  1  UART transmitter accepts ascii_out this cycle.
REQ-010 frame_cnt  output  8  count of fully emitted frames; wraps 255->0.

Function
REQ-011 The FSM SHALL have the states IDLE, HI, LO, CR and LF, encoded in 3 bits.
REQ-012 In IDLE: data_ready=1, ascii_valid=0.
REQ-013 Input handshake: data_valid=1 and data_ready=1 on an edge -> capture data_in, go to HI.
REQ-014 On that same edge: data_ready->0, ascii_valid->1, ascii_out->char(data_in[7:4]).
REQ-015 The first character SHALL appear 1 cycle after the accepting edge.
REQ-016 Nibble map: 0x0-0x9 -> 0x30-0x39; 0xA-0xF -> 0x41-0x46 (uppercase only).
REQ-017 Output handshake: the character is transferred on an edge where ascii_valid=1 and ascii_ready=1.
REQ-018 While ascii_valid=1 and ascii_ready=0, ascii_out and the state SHALL hold; ascii_valid SHALL NOT drop.
REQ-019 HI transfer -> LO, ascii_out=char(low nibble of the captured byte).
REQ-020 LO transfer -> CR with ascii_out=0x0D when CRLF is enabled; otherwise -> IDLE.
REQ-021 CR transfer -> LF, ascii_out=0x0A.
REQ-022 LF transfer -> IDLE.
REQ-023 Each return to IDLE: ascii_valid->0, data_ready->1, frame_cnt incremented by 1 (mod 256).
REQ-024 Back-to-back bytes: a new byte is accepted no earlier than the edge after data_ready returns to 1; there is no input bypass.
REQ-025 data_valid outside IDLE SHALL be ignored; data_in SHALL be sampled only on the accepting edge.
REQ-026 ascii_ready while ascii_valid=0 SHALL have no effect.
REQ-027 Sustained ascii_ready=1 gives one character per cycle: 2 cycles per frame without CRLF, 4 with CRLF.

Reset
REQ-028 On an edge with rst=1, the block SHALL enter IDLE with data_ready=1, ascii_valid=0, ascii_out=0x00 and frame_cnt=0x00.
REQ-029 rst SHALL take priority over all handshakes.
REQ-030 Reset mid-frame SHALL abort the frame: the remaining characters are not sent and frame_cnt is not incremented.
REQ-031 A data_valid on the reset edge SHALL NOT be captured.

Configuration
REQ-032 The macro HEX2ASCII_TX_CRLF_EN SHALL control the CR/LF suffix.
REQ-033 Defined: every frame is hi, lo, 0x0D, 0x0A, using states CR and LF.
REQ-034 Undefined: every frame is hi, lo only; CR and LF are unreachable and may be removed by synthesis.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset, then data_in=0x3A with ascii_ready held 1, CRLF_EN on -> 0x33, 0x41, 0x0D, 0x0A on consecutive cycles; frame_cnt=1.
- data_in=0xF0, CRLF_EN off, ascii_ready=1 -> 0x46, 0x30; data_ready=1 on the cycle after the second transfer.
- data_in=0x9B, ascii_ready=0 for 5 cycles then 1 -> ascii_out holds 0x39 with ascii_valid=1 through the stall, then 0x42.
- data_valid pulsed with 0x55 while in LO -> ignored; output sequence of the current byte unchanged.
- rst asserted in state CR -> next cycle IDLE, ascii_valid=0, ascii_out=0x00, frame_cnt=0.
- 256 frames of 0x00 -> frame_cnt wraps to 0x00, each frame reads 0x30, 0x30 (plus 0x0D, 0x0A if CRLF_EN).

Source files
------------

// File: rtl/hex2ascii_tx.sv
// Renders each accepted byte as two uppercase ASCII hex characters toward a UART, one char per handshake.
// Define HEX2ASCII_TX_CRLF_EN to append CR, LF to every frame; otherwise frames are hi, lo only.
module hex2ascii_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        CR   = 3'd3,
        LF   = 3'd4
    } state_t;

    state_t     state_q;
    logic [7:0] byte_q;
    logic [7:0] ascii_q;
    logic [7:0] cnt_q;
    logic       rdy_q;
    logic       vld_q;

    logic [7:0] hi_chr_d;
    logic [7:0] lo_chr_d;
    logic [7:0] cnt_d;

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    assign hi_chr_d = hex_chr(data_in[7:4]);
    assign lo_chr_d = hex_chr(byte_q[3:0]);
    assign cnt_d    = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            byte_q  <= 8'h00;
            ascii_q <= 8'h00;
            cnt_q   <= 8'h00;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_valid && rdy_q) begin
                        byte_q  <= data_in;
                        ascii_q <= hi_chr_d;
                        rdy_q   <= 1'b0;
                        vld_q   <= 1'b1;
                        state_q <= HI;
                    end
                end
                HI: begin
                    if (ascii_ready) begin
                        ascii_q <= lo_chr_d;
                        state_q <= LO;
                    end
                end
                LO: begin
                    if (ascii_ready) begin
`ifdef HEX2ASCII_TX_CRLF_EN
                        ascii_q <= 8'h0D;
                        state_q <= CR;
`else
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        cnt_q   <= cnt_d;
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef HEX2ASCII_TX_CRLF_EN
                CR: begin
                    if (ascii_ready) begin
                        ascii_q <= 8'h0A;
                        state_q <= LF;
                    end
                end
                LF: begin
                    if (ascii_ready) begin
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        cnt_q   <= cnt_d;
                        state_q <= IDLE;
                    end
                end
`endif
                // Unreachable encodings recover to a clean idle without counting a frame.
                default: begin
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_ready  = rdy_q;
    assign ascii_out   = ascii_q;
    assign ascii_valid = vld_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_hex2ascii_tx.sv
// Directed + random bench for hex2ascii_tx against a character-queue reference model.
module tb_hex2ascii_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       ascii_ready = 1'b0;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    hex2ascii_tx dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .ascii_out   (ascii_out),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .frame_cnt   (frame_cnt)
    );

`ifdef HEX2ASCII_TX_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif
    localparam int FLEN = CRLF ? 4 : 2;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    int          m_cnt = 0;
    logic [7:0]  log_q[$];
    string       hx = "0123456789ABCDEF";
    logic [7:0]  e[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, model the edge, check at the next negedge.
    task automatic step(input logic dv, input logic [7:0] din, input logic ar, input logic r);
        data_valid  = dv;
        data_in     = din;
        ascii_ready = ar;
        rst         = r;
        #1;
        if (!r && ascii_valid === 1'b1 && ar) log_q.push_back(ascii_out);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_cnt = 0;
        end else if (exp_q.size() == 0) begin
            if (dv) begin
                exp_q.push_back(8'(hx[int'(din[7:4])]));
                exp_q.push_back(8'(hx[int'(din[3:0])]));
                if (CRLF) begin
                    exp_q.push_back(8'h0D);
                    exp_q.push_back(8'h0A);
                end
            end
        end else if (ar) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_cnt = (m_cnt + 1) % 256;
        end
        @(negedge clk);
        chk("m_valid", 32'(ascii_valid), 32'(exp_q.size() != 0));
        chk("m_ready", 32'(data_ready), 32'(exp_q.size() == 0));
        chk("m_cnt", 32'(frame_cnt), 32'(m_cnt));
        if (exp_q.size() != 0) chk("m_out", 32'(ascii_out), 32'(exp_q[0]));
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(FLEN));
        for (int i = 0; i < FLEN; i++) chk({tag, "_chr"}, 32'(log_q[i]), 32'(e[i]));
    endtask

    initial begin
        int bad;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(data_ready), 32'd1);
        chk("rst_valid", 32'(ascii_valid), 32'd0);
        chk("rst_out", 32'(ascii_out), 32'h00);
        chk("rst_cnt", 32'(frame_cnt), 32'h00);

        // 0x3A streamed with ascii_ready held high
        log_q.delete();
        e = '{8'h33, 8'h41, 8'h0D, 8'h0A};
        step(1'b1, 8'h3A, 1'b1, 1'b0);
        repeat (FLEN) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_log("s3a");
        chk("s3a_cnt", 32'(frame_cnt), 32'd1);
        chk("s3a_ready", 32'(data_ready), 32'd1);

        // 0xF0: data_ready back the cycle after the last transfer
        log_q.delete();
        e = '{8'h46, 8'h30, 8'h0D, 8'h0A};
        step(1'b1, 8'hF0, 1'b1, 1'b0);
        repeat (FLEN) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_log("sf0");
        chk("sf0_ready", 32'(data_ready), 32'd1);
        chk("sf0_cnt", 32'(frame_cnt), 32'd2);

        // 0x9B with a 5-cycle stall on the first character
        step(1'b1, 8'h9B, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            chk("stall_out", 32'(ascii_out), 32'h39);
            chk("stall_valid", 32'(ascii_valid), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stall_next", 32'(ascii_out), 32'h42);
        repeat (FLEN - 1) step(1'b0, 8'h00, 1'b1, 1'b0);

        // data_valid pulsed while in LO and on the frame's final edge is ignored
        log_q.delete();
        e = '{8'h31, 8'h32, 8'h0D, 8'h0A};
        step(1'b1, 8'h12, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ign_out", 32'(ascii_out), 32'h32);
        repeat (FLEN - 1) step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("ign_valid", 32'(ascii_valid), 32'd0);
        chk("ign_ready", 32'(data_ready), 32'd1);
        chk_log("ign");
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // reset mid-frame (CR with suffix, LO without) with data_valid on the reset edge
        step(1'b1, 8'hC7, 1'b1, 1'b0);
        repeat (FLEN / 2) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_valid", 32'(ascii_valid), 32'd1);
        step(1'b1, 8'hAA, 1'b1, 1'b1);
        chk("mid_rst_valid", 32'(ascii_valid), 32'd0);
        chk("mid_rst_out", 32'(ascii_out), 32'h00);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'h00);
        chk("mid_rst_ready", 32'(data_ready), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_nocap", 32'(ascii_valid), 32'd0);

        // 256 frames of 0x00: counter wraps back to zero
        log_q.delete();
        for (int f = 0; f < 256; f++) begin
            step(1'b1, 8'h00, 1'b1, 1'b0);
            repeat (FLEN) step(1'b0, 8'h00, 1'b1, 1'b0);
            if (f == 127) chk("wrap_mid", 32'(frame_cnt), 32'd128);
        end
        chk("wrap_cnt", 32'(frame_cnt), 32'h00);
        chk("wrap_len", 32'(log_q.size()), 32'(256 * FLEN));
        bad = 0;
        foreach (log_q[i]) begin
            if ((i % FLEN) < 2) begin
                if (log_q[i] !== 8'h30) bad++;
            end else if ((i % FLEN) == 2) begin
                if (log_q[i] !== 8'h0D) bad++;
            end else if (log_q[i] !== 8'h0A) bad++;
        end
        chk("wrap_chars", 32'(bad), 32'd0);

        // random traffic with occasional resets, checked every cycle by the model
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 59) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
